lsu_mem_queue: RTL and testbench
================================

// Module: lsu_mem_queue
// PURPOSE
//  In-order load/store issue queue fused with a memory-request FSM; successor to the fixed 4-deep LSU wrapper.
//  Holds up to QUEUE_DEPTH decoded memory ops, tracks operand readiness from WB_PORTS wakeup buses plus its own completions.
//  Issues the oldest ready op to memory and returns load data to the PRF write/wakeup network.
// PARAMETERS
//  INST_ID_BITS    6   ROB/instruction id width
//  PRN_BITS        6   physical register number width
//  QUEUE_DEPTH     4   entries, power of two >= 2
//  WB_PORTS        4   external wakeup broadcast ports
//  TIMEOUT_CYCLES  64  load wait limit (LSU_LOAD_TIMEOUT_EN only)
// PORTS
//  clk             in   1             clock
//  rst             in   1             asynchronous reset, active-high
//  enq_valid       in   1             op offered
//  enq_ready       out  1             queue can accept (count < QUEUE_DEPTH)
//  enq_inst_id     in   INST_ID_BITS  op id
//  enq_is_store    in   1             1=store, 0=load
//  enq_base_prn    in   PRN_BITS      address base register
//  enq_base_rdy    in   1             base already available
//  enq_data_prn    in   PRN_BITS      store data register (ignored for loads)
//  enq_data_rdy    in   1             store data already available
//  enq_dst_prn     in   PRN_BITS      load destination register
//  enq_offset      in   12            signed byte offset
//  wb_valid        in   [WB_PORTS]    wakeup strobe per port
//  wb_prn          in   [WB_PORTS][PRN_BITS] woken register
//  prf_read_prn    out  [2][PRN_BITS] head base/data prn (combinational from head)
//  prf_op          in   [2][64]       PRF read data, same cycle
//  mem_ren         out  1             read request pulse
//  mem_raddr       out  64            read address
//  mem_rvalid      in   1             read data valid
//  mem_rdata       in   64            read data
//  mem_wen         out  1             write pulse
//  mem_waddr       out  64            write address
//  mem_wdata       out  64            write data
//  out_valid       out  1             completion pulse
//  out_inst_id     out  INST_ID_BITS  completed id
//  out_wen         out  1             PRF write (loads only)
//  out_prn         out  PRN_BITS      destination prn
//  out_data        out  64            load data
//  out_err         out  1             load timed out
// BEHAVIOUR
//  - Reset: all outputs 0 except enq_ready=1; head=tail=count=0; FSM=IDLE; entry ready bits cleared.
//  - Queue: circular, pointers with wrap bit; enqueue when enq_valid&enq_ready; no same-cycle pass-through when full.
//  - Wakeup: entry rdy bit set when any wb_valid[i] with wb_prn[i]==prn, or own out_valid&out_wen with out_prn==prn.
//    Enqueue snoops the same-cycle wakeups/completion: matching operand enters ready.
//  - Head ready: base_rdy & (is_store ? data_rdy : 1). Address = prf_op[0] + sext64(offset), mod 2^64.
//  - FSM IDLE: head ready in cycle N -> registered strobes in N+1; head popped at end of N.
//    Store: N+1 mem_wen=1, mem_waddr, mem_wdata=prf_op[1]; out_valid=1, out_wen=0. Stay IDLE.
//    Load: N+1 mem_ren=1 (one cycle), mem_raddr; go LD_WAIT. Entry held until data returns.
//  - LD_WAIT: mem_rvalid sampled from cycle N+2 on; at rvalid cycle M: pop; M+1 out_valid=1,
//    out_wen=1, out_prn=dst, out_data=mem_rdata; state IDLE; next issue decided in M+1.
//  - One memory op in flight at a time; strict program order (head only).
//  - mem_rvalid outside LD_WAIT ignored. All strobes single-cycle; data outputs hold last value.
//  - Reset mid-load: returns to IDLE, queue emptied, later rvalid ignored.
//  - Simultaneous enq and pop: count unchanged; enq_ready stays consistent with pre-edge count.
// CONFIGURATION
//  - LSU_LOAD_TIMEOUT_EN defined: counter runs in LD_WAIT; after TIMEOUT_CYCLES cycles without rvalid,
//    pop, next cycle out_valid=1, out_wen=0, out_err=1, state IDLE; later rvalid ignored.
//  - Undefined: LD_WAIT waits indefinitely; out_err tied 0; TIMEOUT_CYCLES unused.
// TESTING
//  - Reset asserted mid-stream -> all outputs 0, enq_ready=1, queue empty.
//  - Load base=0x1000 rdy, offset=-8 -> mem_ren one cycle, raddr=0xFF8; rvalid rdata=0xDEAD 3 cycles later
//    -> next cycle out_valid, out_wen, out_data=0xDEAD, out_prn=dst.
//  - Store data prn 5 not ready; wb_valid[2] prn 5 at cycle 4 -> mem_wen cycle 6, wdata=prf_op[1], out_wen=0.
//  - Enqueue 4 blocked ops -> enq_ready=0, 5th held; wakeup head -> after pop enq_ready=1, 5th accepted.
//  - Load dst=9 then load base=9 -> second mem_ren exactly one cycle after first out_valid (self-wakeup).
//  - LSU_LOAD_TIMEOUT_EN: no rvalid for 64 cycles -> out_valid, out_err=1, out_wen=0; late rvalid ignored.

Source files
------------

// File: rtl/lsu_mem_queue_if.sv
// Bundles the LSU queue's request, wakeup, PRF, memory and completion signals.
// Parameters: INST_ID_BITS, PRN_BITS, WB_PORTS (must match the lsu_mem_queue instance).
// Modports:
//   master - the core/memory side: drives enqueue, wakeup, PRF data and memory
//            read responses; observes everything the queue produces.
//   slave  - the lsu_mem_queue side.
// Signal groups:
//   enq_*        decoded memory op offered to the queue (valid/ready handshake)
//   wb_*         external wakeup broadcast ports
//   prf_*        head operand read (prn out, data back in the same cycle)
//   mem_*        single-outstanding memory read/write port
//   out_*        completion / PRF write-back port
interface lsu_mem_queue_if #(
    parameter int unsigned INST_ID_BITS = 6,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned WB_PORTS     = 4
);
    logic                                enq_valid;
    logic                                enq_ready;
    logic [INST_ID_BITS-1:0]             enq_inst_id;
    logic                                enq_is_store;
    logic [PRN_BITS-1:0]                 enq_base_prn;
    logic                                enq_base_rdy;
    logic [PRN_BITS-1:0]                 enq_data_prn;
    logic                                enq_data_rdy;
    logic [PRN_BITS-1:0]                 enq_dst_prn;
    logic [11:0]                         enq_offset;

    logic [WB_PORTS-1:0]                 wb_valid;
    logic [WB_PORTS-1:0][PRN_BITS-1:0]   wb_prn;

    logic [1:0][PRN_BITS-1:0]            prf_read_prn;
    logic [1:0][63:0]                    prf_op;

    logic                                mem_ren;
    logic [63:0]                         mem_raddr;
    logic                                mem_rvalid;
    logic [63:0]                         mem_rdata;
    logic                                mem_wen;
    logic [63:0]                         mem_waddr;
    logic [63:0]                         mem_wdata;

    logic                                out_valid;
    logic [INST_ID_BITS-1:0]             out_inst_id;
    logic                                out_wen;
    logic [PRN_BITS-1:0]                 out_prn;
    logic [63:0]                         out_data;
    logic                                out_err;

    modport master (
        output enq_valid, enq_inst_id, enq_is_store, enq_base_prn, enq_base_rdy,
               enq_data_prn, enq_data_rdy, enq_dst_prn, enq_offset,
               wb_valid, wb_prn, prf_op, mem_rvalid, mem_rdata,
        input  enq_ready, prf_read_prn, mem_ren, mem_raddr, mem_wen, mem_waddr,
               mem_wdata, out_valid, out_inst_id, out_wen, out_prn, out_data, out_err
    );

    modport slave (
        input  enq_valid, enq_inst_id, enq_is_store, enq_base_prn, enq_base_rdy,
               enq_data_prn, enq_data_rdy, enq_dst_prn, enq_offset,
               wb_valid, wb_prn, prf_op, mem_rvalid, mem_rdata,
        output enq_ready, prf_read_prn, mem_ren, mem_raddr, mem_wen, mem_waddr,
               mem_wdata, out_valid, out_inst_id, out_wen, out_prn, out_data, out_err
    );
endinterface

// File: rtl/lsu_mem_queue.sv
// In-order load/store issue queue fused with a single-outstanding memory FSM.
// Holds up to QUEUE_DEPTH decoded ops, tracks base/data operand readiness from
// the WB_PORTS wakeup buses and its own load completions, issues the head op
// when ready, and returns load data on the completion port.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - lsu_mem_queue_if.slave (enqueue, wakeup, PRF read, memory, completion)
// Optional feature:
//   LSU_LOAD_TIMEOUT_EN - when defined, a load waiting TIMEOUT_CYCLES cycles
//   without read data completes with out_err=1; otherwise loads wait forever
//   and out_err is tied low.
module lsu_mem_queue #(
    parameter int unsigned INST_ID_BITS   = 6,
    parameter int unsigned PRN_BITS       = 6,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter int unsigned WB_PORTS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    lsu_mem_queue_if.slave bus
);
    localparam int unsigned AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [INST_ID_BITS-1:0] inst_id;
        logic                    is_store;
        logic [PRN_BITS-1:0]     base_prn;
        logic                    base_rdy;
        logic [PRN_BITS-1:0]     data_prn;
        logic                    data_rdy;
        logic [PRN_BITS-1:0]     dst_prn;
        logic [11:0]             offset;
    } entry_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LD_WAIT = 1'b1
    } state_t;

    state_t          state, state_d;
    entry_t          q [QUEUE_DEPTH];
    entry_t          head_e;
    entry_t          enq_entry;
    logic [PW-1:0]   head, tail, count;
    logic            enq_fire;
    logic            pop;
    logic            self_v;
    logic            head_base_ok, head_data_ok, head_rdy;
    logic [63:0]     ea;

    // next values of the registered outputs
    logic                    mem_ren_d, mem_wen_d;
    logic [63:0]             mem_raddr_d, mem_waddr_d, mem_wdata_d;
    logic                    out_valid_d, out_wen_d;
    logic [INST_ID_BITS-1:0] out_inst_d;
    logic [PRN_BITS-1:0]     out_prn_d;
    logic [63:0]             out_data_d;

`ifdef LSU_LOAD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt, tmo_d;
    logic          out_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // True when prn is being produced this cycle by a wakeup port or our own load completion.
    function automatic logic wakes(
        input logic [PRN_BITS-1:0]               prn,
        input logic [WB_PORTS-1:0]               wv,
        input logic [WB_PORTS-1:0][PRN_BITS-1:0] wp,
        input logic                              sv,
        input logic [PRN_BITS-1:0]               sp
    );
        logic hit;
        hit = sv && (sp == prn);
        for (int i = 0; i < WB_PORTS; i++) begin
            if (wv[i] && (wp[i] == prn)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Occupancy from wrap-bit pointers; enq_ready reflects the pre-edge count.
    assign count         = tail - head;
    assign bus.enq_ready = (count < PW'(QUEUE_DEPTH));
    assign enq_fire      = bus.enq_valid & bus.enq_ready;
    assign head_e        = q[head[AW-1:0]];
    assign self_v        = bus.out_valid & bus.out_wen;

    assign bus.prf_read_prn[0] = head_e.base_prn;
    assign bus.prf_read_prn[1] = head_e.data_prn;

    // Own completion is bypassed into head readiness so a dependent load issues
    // in the same cycle its producer's data is written back.
    assign head_base_ok = head_e.base_rdy | (self_v && (bus.out_prn == head_e.base_prn));
    assign head_data_ok = head_e.data_rdy | (self_v && (bus.out_prn == head_e.data_prn));
    assign head_rdy     = (count != '0) && head_base_ok && (head_e.is_store ? head_data_ok : 1'b1);
    assign ea           = bus.prf_op[0] + {{52{head_e.offset[11]}}, head_e.offset};

    // Incoming entry snoops same-cycle wakeups so it cannot miss a broadcast.
    always_comb begin
        enq_entry.inst_id  = bus.enq_inst_id;
        enq_entry.is_store = bus.enq_is_store;
        enq_entry.base_prn = bus.enq_base_prn;
        enq_entry.base_rdy = bus.enq_base_rdy |
                             wakes(bus.enq_base_prn, bus.wb_valid, bus.wb_prn, self_v, bus.out_prn);
        enq_entry.data_prn = bus.enq_data_prn;
        enq_entry.data_rdy = bus.enq_data_rdy |
                             wakes(bus.enq_data_prn, bus.wb_valid, bus.wb_prn, self_v, bus.out_prn);
        enq_entry.dst_prn  = bus.enq_dst_prn;
        enq_entry.offset   = bus.enq_offset;
    end

    // Queue storage, wakeup tracking and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (wakes(q[i].base_prn, bus.wb_valid, bus.wb_prn, self_v, bus.out_prn))
                    q[i].base_rdy <= 1'b1;
                if (wakes(q[i].data_prn, bus.wb_valid, bus.wb_prn, self_v, bus.out_prn))
                    q[i].data_rdy <= 1'b1;
            end
            if (enq_fire) begin
                q[tail[AW-1:0]] <= enq_entry;
                tail            <= tail + PW'(1);
            end
            if (pop) head <= head + PW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state, pop decision and next registered-output values.
    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;
        mem_raddr_d = bus.mem_raddr;
        mem_waddr_d = bus.mem_waddr;
        mem_wdata_d = bus.mem_wdata;
        out_valid_d = 1'b0;
        out_wen_d   = 1'b0;
        out_inst_d  = bus.out_inst_id;
        out_prn_d   = bus.out_prn;
        out_data_d  = bus.out_data;
`ifdef LSU_LOAD_TIMEOUT_EN
        out_err_d   = 1'b0;
        tmo_d       = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (head_rdy) begin
                    if (head_e.is_store) begin
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = ea;
                        mem_wdata_d = bus.prf_op[1];
                        out_valid_d = 1'b1;
                        out_inst_d  = head_e.inst_id;
                        pop         = 1'b1;
                    end else begin
                        // Load stays at the head until its data (or timeout) returns.
                        mem_ren_d   = 1'b1;
                        mem_raddr_d = ea;
                        state_d     = LD_WAIT;
`ifdef LSU_LOAD_TIMEOUT_EN
                        tmo_d       = '0;
`endif
                    end
                end
            end
            LD_WAIT: begin
                // Response is not accepted in the request cycle itself.
                if (bus.mem_rvalid && !bus.mem_ren) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_wen_d   = 1'b1;
                    out_inst_d  = head_e.inst_id;
                    out_prn_d   = head_e.dst_prn;
                    out_data_d  = bus.mem_rdata;
                    state_d     = IDLE;
                end
`ifdef LSU_LOAD_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b1;
                    out_inst_d  = head_e.inst_id;
                    state_d     = IDLE;
                end else begin
                    tmo_d       = tmo_cnt + TW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered memory and completion outputs; strobes pulse, data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_ren     <= 1'b0;
            bus.mem_raddr   <= '0;
            bus.mem_wen     <= 1'b0;
            bus.mem_waddr   <= '0;
            bus.mem_wdata   <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_wen     <= 1'b0;
            bus.out_inst_id <= '0;
            bus.out_prn     <= '0;
            bus.out_data    <= '0;
        end else begin
            bus.mem_ren     <= mem_ren_d;
            bus.mem_raddr   <= mem_raddr_d;
            bus.mem_wen     <= mem_wen_d;
            bus.mem_waddr   <= mem_waddr_d;
            bus.mem_wdata   <= mem_wdata_d;
            bus.out_valid   <= out_valid_d;
            bus.out_wen     <= out_wen_d;
            bus.out_inst_id <= out_inst_d;
            bus.out_prn     <= out_prn_d;
            bus.out_data    <= out_data_d;
        end
    end

`ifdef LSU_LOAD_TIMEOUT_EN
    // Load wait counter and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            bus.out_err <= 1'b0;
        end else begin
            tmo_cnt     <= tmo_d;
            bus.out_err <= out_err_d;
        end
    end
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_queue.sv
// Directed bench for lsu_mem_queue: reset, load path, store wakeup, enqueue
// snoop and response filtering, full-queue backpressure, self-wakeup and the
// load-wait behaviour (timeout or indefinite, depending on LSU_LOAD_TIMEOUT_EN).
module tb_lsu_mem_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [63:0] prf [64];

    lsu_mem_queue_if bus ();

    lsu_mem_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // PRF model: same-cycle read of the head's operands.
    always_comb begin
        bus.prf_op[0] = prf[bus.prf_read_prn[0]];
        bus.prf_op[1] = prf[bus.prf_read_prn[1]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic v, input logic [5:0] id, input logic st,
                       input logic [5:0] bp, input logic br, input logic [5:0] dp,
                       input logic dr, input logic [5:0] dst, input logic [11:0] off);
        bus.enq_valid    = v;
        bus.enq_inst_id  = id;
        bus.enq_is_store = st;
        bus.enq_base_prn = bp;
        bus.enq_base_rdy = br;
        bus.enq_data_prn = dp;
        bus.enq_data_rdy = dr;
        bus.enq_dst_prn  = dst;
        bus.enq_offset   = off;
    endtask

    task automatic test_reset();
        step();
        vectors++; if (bus.enq_ready !== 1'b1) begin miscompares++; $display("FAIL rst_enq_ready: got %0h want 1", bus.enq_ready); end
        vectors++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin miscompares++; $display("FAIL rst_mem_strobes: got ren=%0h wen=%0h want 0", bus.mem_ren, bus.mem_wen); end
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_wen !== 1'b0 || bus.out_err !== 1'b0) begin miscompares++; $display("FAIL rst_out_strobes: got v=%0h w=%0h e=%0h want 0", bus.out_valid, bus.out_wen, bus.out_err); end
        vectors++; if (bus.mem_raddr !== 64'h0 || bus.out_data !== 64'h0 || bus.prf_read_prn !== 12'h0) begin miscompares++; $display("FAIL rst_data: got raddr=%0h data=%0h prn=%0h want 0", bus.mem_raddr, bus.out_data, bus.prf_read_prn); end
        rst = 1'b0;
        step();
        vectors++; if (bus.enq_ready !== 1'b1 || bus.mem_ren !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got rdy=%0h ren=%0h want 1/0", bus.enq_ready, bus.mem_ren); end
    endtask

    task automatic test_load();
        enq(1'b1, 6'd1, 1'b0, 6'd3, 1'b1, 6'd0, 1'b0, 6'd9, 12'hFF8);
        step();                                            // cycle 1
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        vectors++; if (bus.mem_ren !== 1'b0 || bus.prf_read_prn[0] !== 6'd3) begin miscompares++; $display("FAIL load_head: got ren=%0h prn=%0d want 0/3", bus.mem_ren, bus.prf_read_prn[0]); end
        step();                                            // cycle 2
        vectors++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 64'hFF8) begin miscompares++; $display("FAIL load_issue: got ren=%0h raddr=%0h want 1/ff8", bus.mem_ren, bus.mem_raddr); end
        step();                                            // cycle 3
        vectors++; if (bus.mem_ren !== 1'b0) begin miscompares++; $display("FAIL load_ren_pulse: got %0h want 0", bus.mem_ren); end
        step();                                            // cycle 4
        step();                                            // cycle 5
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hDEAD;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL load_early_out: got %0h want 0", bus.out_valid); end
        step();                                            // cycle 6
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_wen !== 1'b1 || bus.out_data !== 64'hDEAD || bus.out_prn !== 6'd9 || bus.out_inst_id !== 6'd1) begin miscompares++; $display("FAIL load_complete: got v=%0h w=%0h d=%0h prn=%0d id=%0d want 1/1/dead/9/1", bus.out_valid, bus.out_wen, bus.out_data, bus.out_prn, bus.out_inst_id); end
        step();                                            // cycle 7
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'hDEAD) begin miscompares++; $display("FAIL load_hold: got v=%0h d=%0h want 0/dead", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_store_wakeup();
        enq(1'b1, 6'd2, 1'b1, 6'd4, 1'b1, 6'd5, 1'b0, 6'd0, 12'h010);
        step();                                            // cycle 1
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        step(); step();                                    // cycle 3
        vectors++; if (bus.mem_wen !== 1'b0) begin miscompares++; $display("FAIL store_blocked: got %0h want 0", bus.mem_wen); end
        step();                                            // cycle 4
        bus.wb_valid = 4'b0100; bus.wb_prn[2] = 6'd5;
        step();                                            // cycle 5
        bus.wb_valid = 4'b0000; bus.wb_prn[2] = 6'd0;
        vectors++; if (bus.mem_wen !== 1'b0) begin miscompares++; $display("FAIL store_early: got %0h want 0", bus.mem_wen); end
        step();                                            // cycle 6
        vectors++; if (bus.mem_wen !== 1'b1 || bus.mem_waddr !== 64'h2010 || bus.mem_wdata !== 64'h1234_5678) begin miscompares++; $display("FAIL store_issue: got wen=%0h addr=%0h data=%0h want 1/2010/12345678", bus.mem_wen, bus.mem_waddr, bus.mem_wdata); end
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_wen !== 1'b0 || bus.out_inst_id !== 6'd2) begin miscompares++; $display("FAIL store_out: got v=%0h w=%0h id=%0d want 1/0/2", bus.out_valid, bus.out_wen, bus.out_inst_id); end
        step();                                            // cycle 7
        vectors++; if (bus.mem_wen !== 1'b0 || bus.out_valid !== 1'b0 || bus.mem_wdata !== 64'h1234_5678) begin miscompares++; $display("FAIL store_pulse: got wen=%0h v=%0h data=%0h want 0/0/12345678", bus.mem_wen, bus.out_valid, bus.mem_wdata); end
    endtask

    task automatic test_snoop();
        enq(1'b1, 6'd30, 1'b0, 6'd30, 1'b0, 6'd0, 1'b0, 6'd11, 12'h000);
        bus.wb_valid = 4'b1000; bus.wb_prn[3] = 6'd30;
        step();                                            // cycle 1
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        bus.wb_valid = 4'b0000; bus.wb_prn[3] = 6'd0;
        step();                                            // cycle 2
        vectors++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 64'h8000) begin miscompares++; $display("FAIL snoop_issue: got ren=%0h raddr=%0h want 1/8000", bus.mem_ren, bus.mem_raddr); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD;    // same cycle as request: ignored
        step();                                            // cycle 3
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rvalid_in_req_cycle: got %0h want 0", bus.out_valid); end
        bus.mem_rdata = 64'h600D;
        step();                                            // cycle 4
        bus.mem_rdata = 64'hBAD;                           // IDLE now: ignored
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h600D || bus.out_prn !== 6'd11) begin miscompares++; $display("FAIL snoop_complete: got v=%0h d=%0h prn=%0d want 1/600d/11", bus.out_valid, bus.out_data, bus.out_prn); end
        step();                                            // cycle 5
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h600D) begin miscompares++; $display("FAIL rvalid_idle_ignored: got v=%0h d=%0h want 0/600d", bus.out_valid, bus.out_data); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            enq(1'b1, 6'(10 + k), 1'b1, 6'd20, 1'b0, 6'd21, 1'b1, 6'd0, 12'h100);
            step();
        end
        vectors++; if (bus.enq_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0h want 0", bus.enq_ready); end
        enq(1'b1, 6'd14, 1'b1, 6'd22, 1'b1, 6'd21, 1'b1, 6'd0, 12'h004);
        step();                                            // F: fifth held
        vectors++; if (bus.enq_ready !== 1'b0 || bus.mem_wen !== 1'b0) begin miscompares++; $display("FAIL full_held: got rdy=%0h wen=%0h want 0/0", bus.enq_ready, bus.mem_wen); end
        bus.wb_valid = 4'b0001; bus.wb_prn[0] = 6'd20;
        step();                                            // F+1: head issues, popped at end
        bus.wb_valid = 4'b0000; bus.wb_prn[0] = 6'd0;
        vectors++; if (bus.enq_ready !== 1'b0) begin miscompares++; $display("FAIL full_pre_pop: got %0h want 0", bus.enq_ready); end
        step();                                            // F+2: fifth accepted this cycle
        vectors++; if (bus.enq_ready !== 1'b1 || bus.mem_wen !== 1'b1 || bus.out_inst_id !== 6'd10 || bus.mem_waddr !== 64'h4100) begin miscompares++; $display("FAIL full_first_pop: got rdy=%0h wen=%0h id=%0d addr=%0h want 1/1/10/4100", bus.enq_ready, bus.mem_wen, bus.out_inst_id, bus.mem_waddr); end
        step();                                            // F+3
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        for (int k = 0; k < 3; k++) begin
            vectors++; if (bus.mem_wen !== 1'b1 || bus.out_inst_id !== 6'(11 + k)) begin miscompares++; $display("FAIL b2b_store%0d: got wen=%0h id=%0d want 1/%0d", k, bus.mem_wen, bus.out_inst_id, 11 + k); end
            step();
        end
        vectors++; if (bus.mem_wen !== 1'b1 || bus.out_inst_id !== 6'd14 || bus.mem_waddr !== 64'h6004 || bus.mem_wdata !== 64'hAAAA) begin miscompares++; $display("FAIL fifth_store: got wen=%0h id=%0d addr=%0h data=%0h want 1/14/6004/aaaa", bus.mem_wen, bus.out_inst_id, bus.mem_waddr, bus.mem_wdata); end
        step();
        vectors++; if (bus.mem_wen !== 1'b0 || bus.enq_ready !== 1'b1) begin miscompares++; $display("FAIL full_drained: got wen=%0h rdy=%0h want 0/1", bus.mem_wen, bus.enq_ready); end
    endtask

    task automatic test_self_wakeup();
        enq(1'b1, 6'd20, 1'b0, 6'd3, 1'b1, 6'd0, 1'b0, 6'd9, 12'h000);
        step();                                            // cycle 1
        enq(1'b1, 6'd21, 1'b0, 6'd9, 1'b0, 6'd0, 1'b0, 6'd10, 12'h008);
        step();                                            // cycle 2
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        vectors++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 64'h1000) begin miscompares++; $display("FAIL self_first_issue: got ren=%0h raddr=%0h want 1/1000", bus.mem_ren, bus.mem_raddr); end
        step(); step();                                    // cycle 4
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h5000;
        step();                                            // cycle 5
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_prn !== 6'd9 || bus.mem_ren !== 1'b0) begin miscompares++; $display("FAIL self_first_done: got v=%0h prn=%0d ren=%0h want 1/9/0", bus.out_valid, bus.out_prn, bus.mem_ren); end
        step();                                            // cycle 6
        vectors++; if (bus.mem_ren !== 1'b1 || bus.mem_raddr !== 64'h5008) begin miscompares++; $display("FAIL self_wakeup_issue: got ren=%0h raddr=%0h want 1/5008", bus.mem_ren, bus.mem_raddr); end
        step();                                            // cycle 7: earliest accepted response
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
        step();                                            // cycle 8
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_prn !== 6'd10 || bus.out_data !== 64'h77 || bus.out_inst_id !== 6'd21) begin miscompares++; $display("FAIL self_second_done: got v=%0h prn=%0d d=%0h id=%0d want 1/10/77/21", bus.out_valid, bus.out_prn, bus.out_data, bus.out_inst_id); end
        step();
    endtask

    task automatic test_load_wait();
        int  n;
        logic seen;
        enq(1'b1, 6'd50, 1'b0, 6'd3, 1'b1, 6'd0, 1'b0, 6'd13, 12'h000);
        step();                                            // cycle 1
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        step();                                            // cycle 2
        vectors++; if (bus.mem_ren !== 1'b1) begin miscompares++; $display("FAIL wait_issue: got %0h want 1", bus.mem_ren); end
`ifdef LSU_LOAD_TIMEOUT_EN
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        vectors++; if (n !== 64) begin miscompares++; $display("FAIL timeout_latency: got %0d cycles want 64", n); end
        vectors++; if (bus.out_err !== 1'b1 || bus.out_wen !== 1'b0 || bus.out_inst_id !== 6'd50) begin miscompares++; $display("FAIL timeout_out: got err=%0h wen=%0h id=%0d want 1/0/50", bus.out_err, bus.out_wen, bus.out_inst_id); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h99;
        step();
        bus.mem_rvalid = 1'b0;
        vectors++; if (bus.out_err !== 1'b0 || bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse: got err=%0h v=%0h want 0/0", bus.out_err, bus.out_valid); end
        step();
        vectors++; if (bus.out_valid !== 1'b0 || bus.enq_ready !== 1'b1) begin miscompares++; $display("FAIL late_rvalid: got v=%0h rdy=%0h want 0/1", bus.out_valid, bus.enq_ready); end
        seen = 1'b0;
`else
        seen = 1'b0;
        for (n = 0; n < 80; n++) begin
            step();
            seen = seen | bus.out_valid;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL no_timeout: got out_valid during wait want 0"); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h99;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h99 || bus.out_err !== 1'b0 || bus.out_wen !== 1'b1) begin miscompares++; $display("FAIL long_wait_done: got v=%0h d=%0h err=%0h w=%0h want 1/99/0/1", bus.out_valid, bus.out_data, bus.out_err, bus.out_wen); end
        step();
`endif
    endtask

    task automatic test_reset_mid();
        enq(1'b1, 6'd40, 1'b0, 6'd3, 1'b1, 6'd0, 1'b0, 6'd12, 12'h000);
        step();                                            // cycle 1
        enq(1'b1, 6'd41, 1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd0, 12'h000);
        step();                                            // cycle 2: load requested
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        step();                                            // cycle 3: in LD_WAIT
        rst = 1'b1;
        #1;
        vectors++; if (bus.enq_ready !== 1'b1 || bus.mem_ren !== 1'b0 || bus.mem_raddr !== 64'h0 || bus.out_data !== 64'h0 || bus.prf_read_prn !== 12'h0) begin miscompares++; $display("FAIL mid_reset: got rdy=%0h ren=%0h raddr=%0h d=%0h prn=%0h want 1/0/0/0/0", bus.enq_ready, bus.mem_ren, bus.mem_raddr, bus.out_data, bus.prf_read_prn); end
        step();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD;
        step();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 64'h0;
        step();
        vectors++; if (bus.out_valid !== 1'b0 || bus.mem_wen !== 1'b0 || bus.mem_ren !== 1'b0) begin miscompares++; $display("FAIL post_reset_quiet: got v=%0h wen=%0h ren=%0h want 0/0/0", bus.out_valid, bus.mem_wen, bus.mem_ren); end
        enq(1'b1, 6'd42, 1'b1, 6'd3, 1'b1, 6'd4, 1'b1, 6'd0, 12'h000);
        step();
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        step();
        vectors++; if (bus.mem_wen !== 1'b1 || bus.out_inst_id !== 6'd42 || bus.mem_waddr !== 64'h1000) begin miscompares++; $display("FAIL post_reset_store: got wen=%0h id=%0d addr=%0h want 1/42/1000", bus.mem_wen, bus.out_inst_id, bus.mem_waddr); end
        step();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) prf[i] = 64'h0;
        prf[3]  = 64'h1000;
        prf[4]  = 64'h2000;
        prf[5]  = 64'h1234_5678;
        prf[9]  = 64'h5000;
        prf[20] = 64'h4000;
        prf[21] = 64'hAAAA;
        prf[22] = 64'h6000;
        prf[30] = 64'h8000;
        enq(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 12'h0);
        bus.wb_valid   = '0;
        bus.wb_prn     = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        test_reset();
        test_load();
        test_store_wakeup();
        test_snoop();
        test_full();
        test_self_wakeup();
        test_load_wait();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
